operand_loader: RTL and testbench
=================================

// Module: operand_loader
// PURPOSE
//  Upstream stage of the approximate-multiply engine: fills the 16-bit operand RAM from a valid/ready
//  word stream, then pulses start to the main controller. It waits for the controller's done and
//  reports batch completion. It owns the RAM write port only while filling; the datapath owns it otherwise.
// PARAMETERS
//  DATA_W     16  operand word width, equal to the RAM data width
//  ADDR_W      4  RAM address width
//  NUM_WORDS  16  words per batch; must be even (operands are consumed in pairs); 2 <= NUM_WORDS <= 2**ADDR_W
//  START_LEN   2  cycles the start output is held high (>= 1)
// PORTS
//  clk          in   1       system clock, rising edge
//  rst          in   1       reset; synchronous and active-high
//  in_valid     in   1       upstream word valid
//  in_data      in   DATA_W  upstream operand word
//  in_ready     out  1       loader accepts a word this cycle
//  ram_own      out  1       1 = loader drives the RAM address/write (top-level mux select)
//  ram_wr_en    out  1       RAM write strobe
//  ram_addr     out  ADDR_W  RAM write address
//  ram_wr_data  out  DATA_W  RAM write data
//  start        out  1       start to the controller
//  done         in   1       done from the controller (1-cycle pulse)
//  busy         out  1       batch handed off; waiting for done
//  batch_done   out  1       1-cycle pulse when the controller's done is observed
//  fill_count   out  ADDR_W+1 words written in the current batch
// BEHAVIOUR
//  - Reset (synchronous, rst=1 at clk edge): state=IDLE, addr=0, fill_count=0, start_cnt=0.
//    All outputs are 0 while in IDLE. A reset asserted in any state aborts the batch; the partial RAM
//    contents are don't-care and are never handed to the controller.
//  - FSM, 4 states:
//    IDLE  -> FILL unconditionally on the next cycle.
//    FILL  : in_ready=1, ram_own=1. Handshake = in_valid & in_ready.
//            On a handshake: ram_wr_en=1, ram_addr=addr, ram_wr_data=in_data (combinational, same cycle).
//            addr++ and fill_count++ at the edge.
//            The handshake with fill_count==NUM_WORDS-1 is the last word -> go to START.
//            No handshake -> hold; the RAM is not written.
//    START : start=1 and in_ready=0 for exactly START_LEN cycles (counted by start_cnt).
//            ram_own=1 with ram_wr_en=0 during START, so the datapath does not touch RAM during the controller's START wait.
//            After START_LEN cycles -> WAIT; start drops to 0, which releases the controller's START state.
//    WAIT  : busy=1, ram_own=0, in_ready=0. done=1 -> batch_done=1 (registered, asserts in the cycle
//            after done), addr=0, fill_count=0, then -> FILL.
//  - done is ignored outside WAIT. in_valid and in_data are ignored whenever in_ready=0.
//  - in_data must be stable only in the handshake cycle. The upstream may hold valid high across cycles.
//  - addr is ADDR_W wide and never wraps within a batch, because NUM_WORDS <= 2**ADDR_W.
//    With NUM_WORDS == 2**ADDR_W, addr wraps to 0 on the last word, which is the intended behaviour.
//  - Throughput: 1 word/cycle in FILL. Minimum gap from the last word to start is 0 cycles
//    (start is high in the first cycle after the last handshake).
//  - done arriving in the same cycle WAIT is entered is honoured.
// STRUCTURE
//  - Shared package ca1_pkg: DATA_W, ADDR_W, NUM_WORDS constants; loader state encoding
//    (LD_IDLE=2'b00, LD_FILL=2'b01, LD_START=2'b10, LD_WAIT=2'b11).
//  - One sub-module, cnt_mod_n: an up counter with sync init, enable and carry-out.
//    It is instantiated for addr/fill_count and for start_cnt.
//  - The FSM (state register, next-state logic, output decode) stays in this file.
// TESTING
//  1. Reset, then stream 16 words 0x0001..0x0010 with in_valid always 1 -> writes to addr 0..15 on
//     16 consecutive cycles; start is high for 2 cycles right after; busy=1.
//  2. in_valid toggling 1,0,1,0 -> a write occurs only on valid cycles; fill_count increments only then;
//     no RAM write when in_valid=0.
//  3. After start, drive in_valid=1 with 0xFFFF for 20 cycles before done -> in_ready=0, no ram_wr_en;
//     the RAM still holds batch 1.
//  4. Pulse done 10 cycles into WAIT -> batch_done high exactly 1 cycle later; in_ready=1 next;
//     the next word is written at addr 0.
//  5. Assert rst after 7 words -> all outputs 0 next cycle; a fresh 16-word batch writes from addr 0;
//     start fires only after 16 new words.
//  6. Pulse done during FILL and START -> no effect; batch_done stays 0.

Source files
------------

// File: rtl/ca1_pkg.sv
// Shared constants and loader state encoding for the approximate-multiply engine.
package ca1_pkg;

   localparam int DATA_W    = 16;
   localparam int ADDR_W    = 4;
   localparam int NUM_WORDS = 16;
   localparam int START_LEN = 2;

   typedef enum logic [1:0] {
      LD_IDLE  = 2'b00,
      LD_FILL  = 2'b01,
      LD_START = 2'b10,
      LD_WAIT  = 2'b11
   } ld_state_t;

endpackage

// File: rtl/operand_loader_if.sv
// Operand stream, RAM write port and controller handshake seen by the operand loader.
interface operand_loader_if #(
   parameter int DATA_W = ca1_pkg::DATA_W,
   parameter int ADDR_W = ca1_pkg::ADDR_W
);

   logic              in_valid;
   logic [DATA_W-1:0] in_data;
   logic              in_ready;
   logic              ram_own;
   logic              ram_wr_en;
   logic [ADDR_W-1:0] ram_addr;
   logic [DATA_W-1:0] ram_wr_data;
   logic              start;
   logic              done;
   logic              busy;
   logic              batch_done;
   logic [ADDR_W:0]   fill_count;

   // The loader is the slave of the word stream and the controller's done.
   modport slave (
      input  in_valid, in_data, done,
      output in_ready, ram_own, ram_wr_en, ram_addr, ram_wr_data,
             start, busy, batch_done, fill_count
   );

   modport master (
      output in_valid, in_data, done,
      input  in_ready, ram_own, ram_wr_en, ram_addr, ram_wr_data,
             start, busy, batch_done, fill_count
   );

endinterface

// File: rtl/cnt_mod_n.sv
// Modulo-N up counter with synchronous init, enable and a carry-out on the wrapping increment.
module cnt_mod_n #(
   parameter int W = 4,
   parameter int N = 16
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         init,
   input  logic         en,
   output logic [W-1:0] q,
   output logic         co
);

   assign co = en & (q == W'(N - 1));

   // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
   always_ff @(posedge clk) begin
      if (rst || init) begin
         q <= '0;
      end else if (en) begin
         q <= co ? '0 : q + 1'b1;
      end
   end

endmodule

// File: rtl/operand_loader.sv
// Fills the operand RAM from a valid/ready stream, pulses start to the controller,
// then waits for its done before accepting the next batch.
module operand_loader #(
   parameter int DATA_W    = ca1_pkg::DATA_W,
   parameter int ADDR_W    = ca1_pkg::ADDR_W,
   parameter int NUM_WORDS = ca1_pkg::NUM_WORDS,
   parameter int START_LEN = ca1_pkg::START_LEN
) (
   input logic          clk,
   input logic          rst,
   operand_loader_if.slave bus
);

   import ca1_pkg::*;

   localparam int FC_W = ADDR_W + 1;
   localparam int SC_W = $clog2(START_LEN + 1);

   ld_state_t       state, state_nxt;
   logic            hs, fill_clr, fill_last;
   logic            start_run, start_last;
   logic            batch_done_q;
   logic [FC_W-1:0] fill_cnt;
   logic [SC_W-1:0] start_cnt;

   // Handshake is derived from state, not from in_ready, to keep the decode loop-free.
   assign hs        = bus.in_valid & (state == LD_FILL);
   assign fill_clr  = (state == LD_WAIT) & bus.done;
   assign start_run = (state == LD_START);

   // Wraps on the last word, so addr returns to 0 exactly when the batch is complete.
   cnt_mod_n #(.W(FC_W), .N(NUM_WORDS)) u_fill_cnt (
      .clk  (clk),
      .rst  (rst),
      .init (fill_clr),
      .en   (hs),
      .q    (fill_cnt),
      .co   (fill_last)
   );

   cnt_mod_n #(.W(SC_W), .N(START_LEN)) u_start_cnt (
      .clk  (clk),
      .rst  (rst),
      .init (1'b0),
      .en   (start_run),
      .q    (start_cnt),
      .co   (start_last)
   );

   always_ff @(posedge clk) begin
      if (rst) begin
         state        <= LD_IDLE;
         batch_done_q <= 1'b0;
      end else begin
         state        <= state_nxt;
         batch_done_q <= fill_clr;
      end
   end

   // NOTE: every output and the next state get a default first, so no path can infer a latch.
   always_comb begin
      state_nxt       = state;
      bus.in_ready    = 1'b0;
      bus.ram_own     = 1'b0;
      bus.ram_wr_en   = 1'b0;
      bus.ram_addr    = '0;
      bus.ram_wr_data = '0;
      bus.start       = 1'b0;
      bus.busy        = 1'b0;
      bus.batch_done  = 1'b0;
      bus.fill_count  = '0;

      case (state)
         LD_IDLE: state_nxt = LD_FILL;

         LD_FILL: begin
            bus.in_ready   = 1'b1;
            bus.ram_own    = 1'b1;
            bus.ram_addr   = fill_cnt[ADDR_W-1:0];
            bus.fill_count = fill_cnt;
            bus.batch_done = batch_done_q;
            if (hs) begin
               bus.ram_wr_en   = 1'b1;
               bus.ram_wr_data = bus.in_data;
            end
            if (fill_last) state_nxt = LD_START;
         end

         // RAM stays owned (write idle) so the datapath keeps off it while start is high.
         LD_START: begin
            bus.ram_own    = 1'b1;
            bus.start      = (start_cnt < SC_W'(START_LEN));
            bus.fill_count = FC_W'(NUM_WORDS);
            if (start_last) state_nxt = LD_WAIT;
         end

         LD_WAIT: begin
            bus.busy       = 1'b1;
            bus.fill_count = FC_W'(NUM_WORDS);
            if (bus.done) state_nxt = LD_FILL;
         end

         default: state_nxt = LD_IDLE;
      endcase
   end

endmodule

// File: tb/tb_operand_loader.sv
// Directed bench for operand_loader: full batches, gapped stream, ignored inputs, done timing, mid-batch reset.
module tb_operand_loader;

   import ca1_pkg::*;

   logic clk = 1'b0;
   logic rst;

   always #5 clk = ~clk;

   operand_loader_if bus ();

   operand_loader dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   // Behavioural operand RAM written through the loader's port.
   logic [DATA_W-1:0] mem [2**ADDR_W];
   always @(posedge clk) begin
      if (bus.ram_own && bus.ram_wr_en) mem[bus.ram_addr] <= bus.ram_wr_data;
   end

   int n_checks = 0;
   int n_fail   = 0;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   task automatic cyc();
      @(posedge clk);
      #1;
   endtask

   task automatic drive(input logic v, input logic [DATA_W-1:0] d, input logic dn);
      bus.in_valid = v;
      bus.in_data  = d;
      bus.done     = dn;
      #2;
   endtask

   // Address and data are only meaningful when a write is expected.
   task automatic expect_io(input string tag, input logic ready, input logic own, input logic wr,
                            input logic [ADDR_W-1:0] addr, input logic [DATA_W-1:0] wdata,
                            input logic st, input logic bsy, input logic bdone,
                            input logic [ADDR_W:0] fc);
      check($sformatf("%s.in_ready", tag),   bus.in_ready,   ready);
      check($sformatf("%s.ram_own", tag),    bus.ram_own,    own);
      check($sformatf("%s.ram_wr_en", tag),  bus.ram_wr_en,  wr);
      if (wr) begin
         check($sformatf("%s.ram_addr", tag),    bus.ram_addr,    addr);
         check($sformatf("%s.ram_wr_data", tag), bus.ram_wr_data, wdata);
      end
      check($sformatf("%s.start", tag),      bus.start,      st);
      check($sformatf("%s.busy", tag),       bus.busy,       bsy);
      check($sformatf("%s.batch_done", tag), bus.batch_done, bdone);
      check($sformatf("%s.fill_count", tag), bus.fill_count, fc);
   endtask

   localparam logic [ADDR_W:0] FULL = (ADDR_W+1)'(NUM_WORDS);

   initial begin
      #100000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1);
   end

   initial begin
      rst = 1'b1;
      bus.in_valid = 1'b0;
      bus.in_data  = '0;
      bus.done     = 1'b0;
      cyc();
      cyc();
      drive(1'b0, '0, 1'b0);
      expect_io("reset", 0, 0, 0, '0, '0, 0, 0, 0, '0);

      // IDLE ignores valid and done; all outputs stay low.
      rst = 1'b0;
      drive(1'b1, 16'hAAAA, 1'b1);
      expect_io("idle", 0, 0, 0, '0, '0, 0, 0, 0, '0);
      cyc();

      // Batch 1: back-to-back words 0x0001..0x0010.
      for (int i = 0; i < NUM_WORDS; i++) begin
         drive(1'b1, DATA_W'(i + 1), 1'b0);
         expect_io($sformatf("t1.w%0d", i), 1, 1, 1, ADDR_W'(i), DATA_W'(i + 1), 0, 0, 0,
                   (ADDR_W+1)'(i));
         cyc();
      end

      // START: stream keeps pushing 0xFFFF, done pulsed in the first START cycle.
      drive(1'b1, 16'hFFFF, 1'b1);
      expect_io("t3.start0", 0, 1, 0, '0, '0, 1, 0, 0, FULL);
      cyc();
      drive(1'b1, 16'hFFFF, 1'b0);
      expect_io("t6.start1", 0, 1, 0, '0, '0, 1, 0, 0, FULL);
      cyc();

      for (int k = 0; k < 18; k++) begin
         drive(1'b1, 16'hFFFF, 1'b0);
         expect_io($sformatf("t3.wait%0d", k), 0, 0, 0, '0, '0, 0, 1, 0, FULL);
         cyc();
      end

      drive(1'b1, 16'hFFFF, 1'b1);
      expect_io("t4.done", 0, 0, 0, '0, '0, 0, 1, 0, FULL);
      for (int i = 0; i < NUM_WORDS; i++)
         check($sformatf("t3.mem%0d", i), mem[i], DATA_W'(i + 1));
      cyc();

      // First FILL cycle after done: batch_done pulse and a write at addr 0.
      drive(1'b1, 16'h0100, 1'b0);
      expect_io("t4.refill", 1, 1, 1, '0, 16'h0100, 0, 0, 1, '0);
      cyc();

      // Gapped stream: writes only on valid cycles.
      for (int k = 1; k < 7; k++) begin
         drive(1'b0, 16'hDEAD, 1'b0);
         expect_io($sformatf("t2.gap%0d", k), 1, 1, 0, '0, '0, 0, 0, 0, (ADDR_W+1)'(k));
         cyc();
         drive(1'b1, DATA_W'(16'h0100 + k), 1'b0);
         expect_io($sformatf("t2.w%0d", k), 1, 1, 1, ADDR_W'(k), DATA_W'(16'h0100 + k), 0, 0, 0,
                   (ADDR_W+1)'(k));
         cyc();
      end

      // done during FILL is ignored.
      drive(1'b0, '0, 1'b1);
      expect_io("t6.fill_done", 1, 1, 0, '0, '0, 0, 0, 0, 5'd7);
      cyc();
      drive(1'b0, '0, 1'b0);
      expect_io("t6.fill_after", 1, 1, 0, '0, '0, 0, 0, 0, 5'd7);

      // Abort after 7 words.
      rst = 1'b1;
      cyc();
      drive(1'b1, 16'hBEEF, 1'b1);
      expect_io("t5.reset", 0, 0, 0, '0, '0, 0, 0, 0, '0);
      rst = 1'b0;
      cyc();

      for (int i = 0; i < NUM_WORDS; i++) begin
         drive(1'b1, DATA_W'(16'h3000 + i), 1'b0);
         expect_io($sformatf("t5.w%0d", i), 1, 1, 1, ADDR_W'(i), DATA_W'(16'h3000 + i), 0, 0, 0,
                   (ADDR_W+1)'(i));
         cyc();
      end

      drive(1'b0, '0, 1'b0);
      expect_io("t5.start0", 0, 1, 0, '0, '0, 1, 0, 0, FULL);
      cyc();
      drive(1'b0, '0, 1'b0);
      expect_io("t5.start1", 0, 1, 0, '0, '0, 1, 0, 0, FULL);
      cyc();

      for (int k = 0; k < 10; k++) begin
         drive(1'b0, '0, 1'b0);
         expect_io($sformatf("t4.wait%0d", k), 0, 0, 0, '0, '0, 0, 1, 0, FULL);
         cyc();
      end
      drive(1'b0, '0, 1'b1);
      expect_io("t4.done10", 0, 0, 0, '0, '0, 0, 1, 0, FULL);
      cyc();

      drive(1'b0, '0, 1'b0);
      expect_io("t4.bd_pulse", 1, 1, 0, '0, '0, 0, 0, 1, '0);
      for (int i = 0; i < NUM_WORDS; i++)
         check($sformatf("t5.mem%0d", i), mem[i], DATA_W'(16'h3000 + i));
      cyc();
      drive(1'b0, '0, 1'b0);
      expect_io("t4.bd_end", 1, 1, 0, '0, '0, 0, 0, 0, '0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
